// File: rtl/single_port_mem_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states, slot ops and
// response owners, plus the round-robin grant decision.
package mem_arb_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WAIT_RD = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // A lone full slot always wins; on contention the side not granted last time wins.
  function automatic logic pick_owner(input logic i_full, input logic d_full,
                                      input logic last_grant);
    if (d_full && (!i_full || (last_grant == OWN_I))) return OWN_D;
    return OWN_I;
  endfunction

endpackage

// File: rtl/single_port_mem_arbiter_if.sv
// Fetch, data and shared-memory port bundle; the arbiter takes the slave view,
// the requesters and memory model take the master view.
interface single_port_mem_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  logic                      i_mem_read;
  logic [ADDRESS_BITS-1:0]   i_mem_address_in;
  logic                      i_mem_ready;
  logic                      i_mem_valid;
  logic [DATA_WIDTH-1:0]     i_mem_data_out;
  logic [ADDRESS_BITS-1:0]   i_mem_address_out;

  logic                      d_mem_read;
  logic                      d_mem_write;
  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en;
  logic [ADDRESS_BITS-1:0]   d_mem_address_in;
  logic [DATA_WIDTH-1:0]     d_mem_data_in;
  logic                      d_mem_ready;
  logic                      d_mem_valid;
  logic [DATA_WIDTH-1:0]     d_mem_data_out;
  logic [ADDRESS_BITS-1:0]   d_mem_address_out;

  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_WIDTH/8-1:0]   mem_byte_en;
  logic [ADDRESS_BITS-1:0]   mem_address_in;
  logic [DATA_WIDTH-1:0]     mem_data_in;
  logic                      mem_ready;
  logic                      mem_valid;
  logic [DATA_WIDTH-1:0]     mem_data_out;
  logic [ADDRESS_BITS-1:0]   mem_address_out;

  modport slave (
    input  i_mem_read, i_mem_address_in,
    output i_mem_ready, i_mem_valid, i_mem_data_out, i_mem_address_out,
    input  d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    output d_mem_ready, d_mem_valid, d_mem_data_out, d_mem_address_out,
    output mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    input  mem_ready, mem_valid, mem_data_out, mem_address_out
  );

  modport master (
    output i_mem_read, i_mem_address_in,
    input  i_mem_ready, i_mem_valid, i_mem_data_out, i_mem_address_out,
    output d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    input  d_mem_ready, d_mem_valid, d_mem_data_out, d_mem_address_out,
    input  mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    output mem_ready, mem_valid, mem_data_out, mem_address_out
  );

endinterface

// File: rtl/single_port_mem_arbiter_slot.sv
// One-entry request holding register; clear wins over load so a slot frees
// cleanly on the cycle its transaction retires.
module mem_req_slot #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    op_in,
  input  logic [ADDRESS_BITS-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en_in,
  output logic                    full,
  output logic                    op,
  output logic [ADDRESS_BITS-1:0] address,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] byte_en
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full    <= 1'b0;
      op      <= 1'b0;
      address <= '0;
      data    <= '0;
      byte_en <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      op      <= op_in;
      address <= address_in;
      data    <= data_in;
      byte_en <= byte_en_in;
    end
  end

endmodule

// File: rtl/single_port_mem_arbiter.sv
// Round-robin arbiter of fetch and data request slots onto one single-port
// memory, one outstanding transaction at a time.
//
//   state      | meaning
//   ST_IDLE    | issue a full slot's command when memory is ready; writes retire here
//   ST_WAIT_RD | read issued, steering the next mem_valid to the owner side
module single_port_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
) (
  input logic                      clock,
  input logic                      reset,
  input logic                      scan,
  single_port_mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [0:0]              state;
  logic                    owner;
  logic                    last_grant;

  logic                    i_full, d_full;
  logic                    i_op, d_op;
  logic [ADDRESS_BITS-1:0] i_addr, d_addr;
  logic [DATA_WIDTH-1:0]   i_data, d_data;
  logic [BE_W-1:0]         i_be, d_be;

  logic                    i_load, d_load, i_clear, d_clear;
  logic                    d_op_in;
  logic                    grant_valid, grant_owner, resp;
  logic                    g_op;
  logic [ADDRESS_BITS-1:0] g_addr;
  logic [DATA_WIDTH-1:0]   g_data;
  logic [BE_W-1:0]         g_be;

  // Trace enable has no functional effect on the arbiter.
  logic unused_scan;
  assign unused_scan = scan;

  assign i_load  = bus.i_mem_read && !i_full;
  assign d_load  = (bus.d_mem_read || bus.d_mem_write) && !d_full;
  assign d_op_in = bus.d_mem_write ? OP_WRITE : OP_READ;

  assign grant_valid = (state == ST_IDLE) && bus.mem_ready && (i_full || d_full);
  assign grant_owner = pick_owner(i_full, d_full, last_grant);
  assign g_op   = (grant_owner == OWN_D) ? d_op   : i_op;
  assign g_addr = (grant_owner == OWN_D) ? d_addr : i_addr;
  assign g_data = (grant_owner == OWN_D) ? d_data : i_data;
  assign g_be   = (grant_owner == OWN_D) ? d_be   : i_be;

  assign resp = (state == ST_WAIT_RD) && bus.mem_valid;

  // Writes retire on issue, reads on their response.
  assign i_clear = (grant_valid && (grant_owner == OWN_I) && (g_op == OP_WRITE)) ||
                   (resp && (owner == OWN_I));
  assign d_clear = (grant_valid && (grant_owner == OWN_D) && (g_op == OP_WRITE)) ||
                   (resp && (owner == OWN_D));

  mem_req_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_BITS(ADDRESS_BITS)) u_i_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (i_load),
    .clear      (i_clear),
    .op_in      (OP_READ),
    .address_in (bus.i_mem_address_in),
    .data_in    ('0),
    .byte_en_in ('0),
    .full       (i_full),
    .op         (i_op),
    .address    (i_addr),
    .data       (i_data),
    .byte_en    (i_be)
  );

  mem_req_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_BITS(ADDRESS_BITS)) u_d_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (d_load),
    .clear      (d_clear),
    .op_in      (d_op_in),
    .address_in (bus.d_mem_address_in),
    .data_in    (bus.d_mem_data_in),
    .byte_en_in (bus.d_mem_byte_en),
    .full       (d_full),
    .op         (d_op),
    .address    (d_addr),
    .data       (d_data),
    .byte_en    (d_be)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_D;
    end else if (state == ST_IDLE) begin
      if (grant_valid) begin
        last_grant <= grant_owner;
        if (g_op == OP_READ) begin
          owner <= grant_owner;
          state <= ST_WAIT_RD;
        end
      end
    end else if (bus.mem_valid) begin
      state <= ST_IDLE;
    end
  end

  assign bus.mem_read       = grant_valid && (g_op == OP_READ);
  assign bus.mem_write      = grant_valid && (g_op == OP_WRITE);
  assign bus.mem_address_in = grant_valid ? g_addr : '0;
  assign bus.mem_data_in    = grant_valid ? g_data : '0;
  assign bus.mem_byte_en    = grant_valid ? g_be   : '0;

  assign bus.i_mem_ready = !i_full;
  assign bus.d_mem_ready = !d_full;

  assign bus.i_mem_valid       = resp && (owner == OWN_I);
  assign bus.d_mem_valid       = resp && (owner == OWN_D);
  assign bus.i_mem_data_out    = bus.i_mem_valid ? bus.mem_data_out    : '0;
  assign bus.i_mem_address_out = bus.i_mem_valid ? bus.mem_address_out : '0;
  assign bus.d_mem_data_out    = bus.d_mem_valid ? bus.mem_data_out    : '0;
  assign bus.d_mem_address_out = bus.d_mem_valid ? bus.mem_address_out : '0;

endmodule
